// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) slave, oversampled on clk_i.
// Receives MSB-first words on MOSI and sends a preloaded word on MISO.
// Ports:
//   clk_i, rst_i        system clock, async active-high reset
//   sclk_i, mosi_i,     SPI pins from the master (asynchronous to clk_i)
//   ss_n_i
//   miso_o              serial data to the master
//   din_i, load_i       word to send and its capture strobe
//   dout_o              last fully received word
//   rx_done_tick_o      one-cycle pulse when dout_o updates
//   busy_o              high while selected
//   overrun_o           sticky: word received while the previous one was unacked
//   ack_i               consumer has read dout_o; clears overrun_o
module spi_slave #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  sclk_i,
   input  logic                  mosi_i,
   input  logic                  ss_n_i,
   output logic                  miso_o,
   input  logic [DATA_WIDTH-1:0] din_i,
   input  logic                  load_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  rx_done_tick_o,
   output logic                  busy_o,
   output logic                  overrun_o,
   input  logic                  ack_i
);

   localparam int unsigned CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
   localparam int unsigned RX_W  = DATA_WIDTH - 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   // Synchronisers and edge-detect history
   logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
   logic                   sclk_prev_q, ss_prev_q;
   logic                   sclk_s, ss_s, mosi_s;
   logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_sync_q <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         ss_prev_q   <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         sclk_prev_q <= sclk_s;
         ss_prev_q   <= ss_s;
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign ss_fall   = ~ss_s & ss_prev_q;
   assign ss_rise   = ss_s & ~ss_prev_q;

   // Frame state; tx_shift MSB drives miso_o directly and is zero when idle
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
   logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
   logic [RX_W-1:0]       rx_shift_q, rx_shift_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  tick_q, tick_d;
   logic                  busy_q, busy_d;
   logic                  overrun_q, overrun_d;
   logic                  pending_q, pending_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         tx_buf_q   <= '0;
         tx_shift_q <= '0;
         rx_shift_q <= '0;
         bit_cnt_q  <= '0;
         dout_q     <= '0;
         tick_q     <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_buf_q   <= tx_buf_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         bit_cnt_q  <= bit_cnt_d;
         dout_q     <= dout_d;
         tick_q     <= tick_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
         pending_q  <= pending_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d    = state_q;
      tx_buf_d   = tx_buf_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      dout_d     = dout_q;
      tick_d     = 1'b0;
      overrun_d  = overrun_q;
      pending_d  = pending_q;

      if (load_i) tx_buf_d = din_i;

      case (state_q)
         IDLE: begin
            if (ss_fall) begin
               state_d    = SHIFT;
               tx_shift_d = tx_buf_q;
               rx_shift_d = '0;
               bit_cnt_d  = '0;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               state_d    = IDLE;
               tx_shift_d = '0;
               bit_cnt_d  = '0;
            end else if (sclk_rise) begin
               rx_shift_d = RX_W'({rx_shift_q, mosi_s});
               if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                  dout_d    = {rx_shift_q, mosi_s};
                  tick_d    = 1'b1;
                  bit_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end else if (sclk_fall) begin
               // A zero count after a fall means the word just completed: start the next one
               if (bit_cnt_q == '0) tx_shift_d = tx_buf_q;
               else                 tx_shift_d = {tx_shift_q[DATA_WIDTH-2:0], 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SHIFT);

      // pending tracks an unacknowledged tick; an ack coincident with a tick acks it
      if (ack_i) begin
         overrun_d = 1'b0;
         pending_d = 1'b0;
      end else if (tick_d) begin
         if (pending_q) overrun_d = 1'b1;
         pending_d = 1'b1;
      end
   end

   assign miso_o         = tx_shift_q[DATA_WIDTH-1];
   assign dout_o         = dout_q;
   assign rx_done_tick_o = tick_q;
   assign busy_o         = busy_q;
   assign overrun_o      = overrun_q;

endmodule
